// File: rtl/lane_merger_if.sv
// Handshake bundle for lane_merger: four upstream lane strobes plus the merged output stream.
// Instantiate it with the same WIDTH as the lane_merger that uses it.
interface lane_merger_if #(
  parameter int unsigned WIDTH = 32
);
  logic [4*WIDTH-1:0] lane_data;
  logic [3:0]         lane_valid;
  logic [3:0]         lane_full;
  logic [3:0]         overflow;
  logic [WIDTH-1:0]   data_out;
  logic [1:0]         lane_id_out;
  logic               valid_out;
  logic               ready_in;

  modport master (
    output lane_data, lane_valid, ready_in,
    input  lane_full, overflow, data_out, lane_id_out, valid_out
  );

  modport slave (
    input  lane_data, lane_valid, ready_in,
    output lane_full, overflow, data_out, lane_id_out, valid_out
  );
endinterface

// File: rtl/lane_merger.sv
// Four per-lane FIFOs drained round-robin into a single held output register.
// Writes to a full lane are dropped and latch a sticky per-lane overflow flag.
module lane_merger #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  lane_merger_if.slave  bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic {StEmpty, StHeld} state_e;

  logic [WIDTH-1:0] mem_q [4][DEPTH];
  logic [PtrW-1:0]  wr_ptr_q [4];
  logic [PtrW-1:0]  wr_ptr_d [4];
  logic [PtrW-1:0]  rd_ptr_q [4];
  logic [PtrW-1:0]  rd_ptr_d [4];
  logic [CntW-1:0]  cnt_q [4];
  logic [CntW-1:0]  cnt_d [4];

  logic [3:0]       nonempty, full, push, pop;
  logic [3:0]       ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [1:0]       grant, scan_idx;
  logic             pop_en;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       lane_id_q, lane_id_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      full[i]     = (cnt_q[i] == CntW'(DEPTH));
      push[i]     = bus.lane_valid[i] & ~full[i];
    end
  end

  // Scan from the farthest candidate back to the nearest so the nearest non-empty lane wins.
  always_comb begin
    grant    = last_grant_q;
    scan_idx = last_grant_q;
    for (int k = 4; k >= 1; k--) begin
      scan_idx = last_grant_q + 2'(k);
      if (nonempty[scan_idx]) grant = scan_idx;
    end
  end

  assign pop_en = ((state_q == StEmpty) || bus.ready_in) && (|nonempty);
  assign pop    = pop_en ? (4'b0001 << grant) : 4'b0000;

  always_comb begin
    ovf_d = ovf_q | (bus.lane_valid & full);
    for (int i = 0; i < 4; i++) begin
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PtrW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PtrW'(1) : rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + CntW'(1);
      else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - CntW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    lane_id_d    = lane_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StEmpty: begin
        if (pop_en) state_d = StHeld;
      end
      StHeld: begin
        if (!pop_en && bus.ready_in) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
    if (pop_en) begin
      data_d       = mem_q[grant][rd_ptr_q[grant]];
      lane_id_d    = grant;
      last_grant_d = grant;
    end
  end

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.lane_data[WIDTH*i +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q        <= '0;
      last_grant_q <= 2'd3;
      data_q       <= '0;
      lane_id_q    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      lane_id_q    <= lane_id_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StEmpty;
    else       state_q <= state_d;
  end

  assign bus.lane_full   = full;
  assign bus.overflow    = ovf_q;
  assign bus.data_out    = data_q;
  assign bus.lane_id_out = lane_id_q;
  assign bus.valid_out   = (state_q == StHeld);

endmodule
